// File: rtl/tri_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tri_bus_arbiter
//  Description : Round-robin arbiter and sequencer for a shared multi-driver
//                bus net. One owner drives at a time, owners are separated by
//                a turnaround gap, and ownership is limited by a hold timeout.
//                Optional macro TRI_BUS_ARB_PARK_EN parks the bus on the last
//                owner while no requester is asking for it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tri_bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = 8,
    parameter int MAX_HOLD   = 15,
    parameter int TURNAROUND = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           last,
    input  logic [N_REQ*DATA_W-1:0]    wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic                       drv_en,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic [DATA_W-1:0]          bus_data,
    output logic                       bus_valid,
    output logic                       timeout
);

    localparam int OW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = 3;

    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0]    TURN_LAST = TW'((TURNAROUND > 0) ? (TURNAROUND - 1) : 0);
    localparam logic [OW-1:0]    LAST_IDX  = OW'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t          r_state, w_state_n;
    logic [N_REQ-1:0] r_gnt, w_gnt_n;
    logic            r_drv_en, w_drv_en_n;
    logic [OW-1:0]   r_owner, w_owner_n;
    logic            r_timeout, w_timeout_n;
    logic [OW-1:0]   r_rr_ptr, w_rr_ptr_n;
    logic [HW-1:0]   r_hold_cnt, w_hold_cnt_n;
    logic [TW-1:0]   r_turn_cnt, w_turn_cnt_n;

    logic            w_found;
    logic [OW-1:0]   w_winner;
    logic [OW-1:0]   w_next_ptr;
    logic            w_own_req;
    logic            w_own_last;

    assign w_own_req  = req[r_owner];
    assign w_own_last = last[r_owner];
    assign w_next_ptr = (r_owner == LAST_IDX) ? '0 : (r_owner + OW'(1));

    // Round-robin search: first set request starting at rr_ptr, wrapping.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(r_rr_ptr) + i) % N_REQ;
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                w_winner = OW'(idx);
            end
        end
    end

    // Next-state and next-output logic for the IDLE/OWN/TURN sequencer.
    always_comb begin
        w_state_n    = r_state;
        w_gnt_n      = r_gnt;
        w_drv_en_n   = r_drv_en;
        w_owner_n    = r_owner;
        w_timeout_n  = 1'b0;
        w_rr_ptr_n   = r_rr_ptr;
        w_hold_cnt_n = r_hold_cnt;
        w_turn_cnt_n = r_turn_cnt;

        case (r_state)
            ST_IDLE: begin
`ifdef TRI_BUS_ARB_PARK_EN
                if (r_drv_en) begin
                    // Parked: the parked owner may resume at once; anyone
                    // else waits for the parked driver to be released.
                    if (w_own_req) begin
                        w_state_n    = ST_OWN;
                        w_hold_cnt_n = '0;
                    end else if (|req) begin
                        w_gnt_n      = '0;
                        w_drv_en_n   = 1'b0;
                        w_turn_cnt_n = '0;
                        w_state_n    = (TURNAROUND > 0) ? ST_TURN : ST_IDLE;
                    end
                end else if (w_found) begin
                    w_state_n    = ST_OWN;
                    w_gnt_n      = ONE_HOT0 << w_winner;
                    w_owner_n    = w_winner;
                    w_drv_en_n   = 1'b1;
                    w_hold_cnt_n = '0;
                end else begin
                    w_gnt_n    = ONE_HOT0 << r_owner;
                    w_drv_en_n = 1'b1;
                end
`else
                w_gnt_n    = '0;
                w_drv_en_n = 1'b0;
                if (w_found) begin
                    w_state_n    = ST_OWN;
                    w_gnt_n      = ONE_HOT0 << w_winner;
                    w_owner_n    = w_winner;
                    w_drv_en_n   = 1'b1;
                    w_hold_cnt_n = '0;
                end
`endif
            end

            ST_OWN: begin
                if (!w_own_req || w_own_last || (r_hold_cnt == HOLD_LAST)) begin
                    // Timeout only when neither a drop nor a last beat ended it.
                    w_timeout_n  = w_own_req && !w_own_last;
                    w_gnt_n      = '0;
                    w_drv_en_n   = 1'b0;
                    w_rr_ptr_n   = w_next_ptr;
                    w_turn_cnt_n = '0;
                    w_state_n    = (TURNAROUND > 0) ? ST_TURN : ST_IDLE;
                end else begin
                    w_hold_cnt_n = r_hold_cnt + HW'(1);
                end
            end

            ST_TURN: begin
                w_gnt_n      = '0;
                w_drv_en_n   = 1'b0;
                w_turn_cnt_n = r_turn_cnt + TW'(1);
                if (r_turn_cnt == TURN_LAST) begin
                    w_state_n = ST_IDLE;
                end
            end

            default: begin
                w_state_n  = ST_IDLE;
                w_gnt_n    = '0;
                w_drv_en_n = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the driver immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_drv_en   <= 1'b0;
            r_owner    <= '0;
            r_timeout  <= 1'b0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_turn_cnt <= '0;
        end else begin
            r_state    <= w_state_n;
            r_gnt      <= w_gnt_n;
            r_drv_en   <= w_drv_en_n;
            r_owner    <= w_owner_n;
            r_timeout  <= w_timeout_n;
            r_rr_ptr   <= w_rr_ptr_n;
            r_hold_cnt <= w_hold_cnt_n;
            r_turn_cnt <= w_turn_cnt_n;
        end
    end

    assign gnt       = r_gnt;
    assign drv_en    = r_drv_en;
    assign owner     = r_owner;
    assign timeout   = r_timeout;
    // A parked driver puts zero on the bus and never flags a beat.
    assign bus_valid = r_drv_en && (r_state == ST_OWN) && w_own_req;
    assign bus_data  = (r_drv_en && (r_state == ST_OWN)) ?
                       wdata[r_owner*DATA_W +: DATA_W] : '0;

endmodule
`default_nettype wire

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared multi-driver bus net: N_REQ requesters share one DATA_W-bit bus.
- Exactly one requester drives the bus at a time.
- Enforces a turnaround gap between owners so resolved nets (tri/triand) never see contention.
- Limits ownership with a hold timeout; sits between requester ports and the shared net's drivers.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_W, 8, bus data width
- MAX_HOLD, 15, max cycles one owner may keep the bus (>=1)
- TURNAROUND, 1, idle cycles between owners (0..7)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  request per requester; level, held while wanting the bus
- last  input  N_REQ  final beat marker, qualified by req[i] of the current owner
- wdata  input  N_REQ*DATA_W  packed per-requester data; slice i = wdata[i*DATA_W +: DATA_W]
- gnt  output  N_REQ  one-hot grant, registered
- drv_en  output  1  bus driver enable, registered
- owner  output  $clog2(N_REQ)  index of current or last owner, registered
- bus_data  output  DATA_W  wdata slice of owner when drv_en=1, else 0; combinational from registered state
- bus_valid  output  1  drv_en & req[owner]
- timeout  output  1  one-cycle pulse when an owner is forced off

Behaviour:
- Reset (async, rst_n=0): gnt=0, drv_en=0, owner=0, timeout=0, rr_ptr=0, hold_cnt=0, state=IDLE; bus_data=0 and bus_valid=0 follow. Reset mid-grant drops drv_en immediately; no partial beat is flagged.
- FSM states: IDLE, OWN, TURN.
- IDLE:
  - If any req, pick the first set req scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
  - Next edge: state=OWN, gnt=onehot(winner), owner=winner, drv_en=1, hold_cnt=0. Request-to-grant latency is 1 cycle.
- OWN: one beat transfers in each cycle with bus_valid=1. Release is evaluated in priority order; any release takes effect at the next edge:
  - req[owner]=0: release; no beat that cycle.
  - req[owner]&last[owner]: the beat transfers, then release.
  - hold_cnt==MAX_HOLD-1 with neither condition above: the beat transfers, release, timeout=1 for exactly the next cycle.
  - Otherwise hold_cnt++. The counter is $clog2(MAX_HOLD+1) bits and never wraps.
- On any release:
  - gnt=0, drv_en=0, rr_ptr=(owner+1) mod N_REQ. The owner register keeps its value.
  - If TURNAROUND>0, go to TURN with turn_cnt=0.
  - If TURNAROUND=0, go to IDLE; arbitration runs that IDLE cycle, giving a minimum one-cycle gap between owners.
- TURN: drv_en=0, gnt=0. Increment turn_cnt; when turn_cnt==TURNAROUND-1, go to IDLE. Requests are ignored until IDLE.
- Gap between owners is TURNAROUND+1 cycles of drv_en=0 (IDLE arbitration cycle included).
- Timed-out requester is not blocked; it re-competes at the lowest rotation priority.
- req changes during TURN or IDLE are sampled only at the IDLE arbitration edge.
- Invariants (assertion-checked):
  - gnt is one-hot or zero.
  - drv_en == |gnt.
  - gnt never changes from one non-zero value to a different non-zero value without >=1 cycle of gnt=0.

Optional Feature:
- Macro: TRI_BUS_ARB_PARK_EN.
- Defined:
  - In IDLE with no req, the bus parks on the last owner: gnt=onehot(owner), drv_en=1, bus_data=0, bus_valid=0.
  - A req from the parked owner enters OWN next edge with no turnaround.
  - A req from any other requester first goes through TURN (parked driver released) and then arbitrates.
  - After reset, parking starts on index 0 one cycle after rst_n rises.
- Undefined: IDLE drives nothing (gnt=0, drv_en=0); behaviour exactly as above.

Test Plan:
- Reset with all req=1, N_REQ=4, TURNAROUND=1 → gnt=0001 one cycle after rst_n rises; after requester 0 asserts last, gnt=0 for 2 cycles, then gnt=0010.
- Only req[2] held 20 cycles, last=0, MAX_HOLD=15 → bus_valid=1 for exactly 15 cycles, timeout pulses once, drv_en=0 for 2 cycles, then gnt=0100 again.
- req[1] with wdata slice 1 = 8'hA5 → bus_data=8'hA5 while gnt=0010; bus_data=8'h00 in every drv_en=0 cycle.
- Owner 3 drops req mid-burst with req[0] pending → bus_valid=0 that cycle; gnt=0001 after 2 gap cycles; rr_ptr wraps 3→0.
- rst_n pulsed low during OWN → gnt, drv_en and bus_valid go 0 asynchronously, before the next clk edge.
- With TRI_BUS_ARB_PARK_EN, no requests after owner 1 releases → drv_en=1, bus_valid=0, gnt=0010; req[1] reasserts → bus_valid=1 next cycle with no gap.
